// File: rtl/sync_fifo_flow_pkg.sv
// sync_fifo_flow_pkg: width helpers shared by the flow-controlled FIFO and its storage
package sync_fifo_flow_pkg;
  function automatic int addr_width(input int depth);
    return depth > 2 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo_flow_regfile.sv
// fifo_regfile: unreset DEPTH x DATA_WIDTH storage, one write port, one asynchronous read port
module fifo_regfile
  import sync_fifo_flow_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flow.sv
// sync_fifo_flow: any-depth valid/ready FIFO with occupancy count, level flags, flush and high-water mark
module sync_fifo_flow
  import sync_fifo_flow_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int ADDR_W = addr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      hwm
);
  if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
    $fatal(1, "sync_fifo_flow: illegal DEPTH/AF_LEVEL/AE_LEVEL");
  end
  logic [ADDR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count_next;
  logic [DATA_WIDTH-1:0] rd_data;
  logic push, pop;
  assign in_ready = count != CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_data = out_valid ? rd_data : '0;
  assign almost_full = count >= CNT_W'(AF_LEVEL);
  assign almost_empty = count <= CNT_W'(AE_LEVEL);
  always_comb
    count_next = flush ? '0 : (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
  // pointers wrap explicitly so DEPTH need not be a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      hwm <= '0;
    end else begin
      wptr <= flush ? '0 : push ? (wptr == ADDR_W'(DEPTH - 1) ? '0 : wptr + 1'b1) : wptr;
      rptr <= flush ? '0 : pop ? (rptr == ADDR_W'(DEPTH - 1) ? '0 : rptr + 1'b1) : rptr;
      count <= count_next;
      if (count_next > hwm) hwm <= count_next;
    end
  fifo_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk(clk),
    .we(push & ~flush),
    .waddr(wptr),
    .wdata(in_data),
    .raddr(rptr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_sync_fifo_flow.sv
// tb_sync_fifo_flow: scoreboard bench for sync_fifo_flow against a queue-based reference model
module tb_sync_fifo_flow;
  localparam int DW = 32;
  localparam int DEPTH = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] out_data;
  logic in_ready, out_valid, almost_full, almost_empty;
  logic [CW-1:0] count, hwm;

  int checks = 0;
  int errors = 0;
  int hwm_m = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  sync_fifo_flow #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .hwm(hwm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n = sb_q.size();
    chk("count", 32'(count), 32'(n));
    chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("out_data", out_data, n != 0 ? sb_q[0] : '0);
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("hwm", 32'(hwm), 32'(hwm_m));
  endtask

  // Monitor: every accepted pop must carry the oldest outstanding entry
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("pop_from_empty", 32'(out_valid), 32'd0);
      else chk("pop_data", out_data, sb_q.pop_front());
    end

  // One clock of stimulus; the expected entry is queued when the push is issued
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    if (iv && !fl && sb_q.size() != DEPTH) sb_q.push_back(d);
    @(posedge clk);
    #1;
    if (fl) sb_q.delete();
    if (sb_q.size() > hwm_m) hwm_m = sb_q.size();
    check_state();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    sb_q.delete();
    hwm_m = 0;
    check_state();
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hFF, 1'b0, 1'b0);
    chk("fill_hwm", 32'(hwm), 32'(DEPTH));
    repeat (DEPTH) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'hB0, 1'b0, 1'b0);
    step(1'b1, 32'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b1, 32'hC0 + 32'(i), sb_q.size() >= 3, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDE, 1'b1, 1'b0);
    chk("full_pop_count", 32'(count), 32'(DEPTH - 1));
    step(1'b1, 32'hDF, 1'b0, 1'b0);
    chk("refill_count", 32'(count), 32'(DEPTH));
    repeat (DEPTH) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h70 + 32'(i), 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hEE, 1'b1, 1'b1);
    chk("flush_hwm", 32'(hwm), 32'd3);
    chk("flush_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    repeat (DEPTH) step(1'b0, '0, 1'b1, 1'b0);
    chk("stress_hwm", 32'(hwm), 32'(hwm_m));
    chk("stress_empty", 32'(count), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
